// File: rtl/control_unit_param.sv
// Fetch/decode/execute control FSM for the multi-register CPU, with wait-state memory and vectored interrupts.
// Moore outputs; memory states stall on mem_ready, and interrupts are only taken at instruction boundaries or in HALT.
module control_unit_param #(
  parameter int NUM_REGS = 4,
  localparam int RSEL_W = $clog2(NUM_REGS),
  localparam int IR_W = 4 + 2 * RSEL_W
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [IR_W-1:0]     IR,
  input  logic [3:0]          CCR_Result,
  input  logic                mem_ready,
  input  logic                IRQ,
  output logic                IR_Load,
  output logic                MAR_Load,
  output logic                PC_Load,
  output logic                PC_Inc,
  output logic                CCR_Load,
  output logic                EPC_Load,
  output logic [NUM_REGS-1:0] Reg_Load,
  output logic [RSEL_W-1:0]   Rd_Sel,
  output logic [RSEL_W-1:0]   Rs_Sel,
  output logic [2:0]          ALU_Sel,
  output logic [1:0]          Bus1_Sel,
  output logic [1:0]          Bus2_Sel,
  output logic                mem_req,
  output logic                write,
  output logic                IACK,
  output logic                Halted
);

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_OP0, S_OP1, S_OP2, S_OP3,
    S_EX, S_HALT, S_INT
  } state_t;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDD  = 4'h2;
  localparam logic [3:0] OP_STD  = 4'h3;
  localparam logic [3:0] OP_BFS  = 4'h4;
  localparam logic [3:0] OP_BFC  = 4'h5;
  localparam logic [3:0] OP_BRA  = 4'h6;
  localparam logic [3:0] OP_MISC = 4'h7;

  state_t state, state_nxt, fetch_or_int;
  logic   int_en, int_en_nxt;

  logic [3:0]          opcode;
  logic [RSEL_W-1:0]   rd, rs;
  logic [NUM_REGS-1:0] rd_onehot;
  logic                flag, taken, uses_operand;

  assign opcode    = IR[IR_W-1 -: 4];
  assign rd        = IR[2*RSEL_W-1 -: RSEL_W];
  assign rs        = IR[RSEL_W-1:0];
  assign rd_onehot = NUM_REGS'(1) << rd;

  assign flag  = CCR_Result[rs[1:0]];
  assign taken = (opcode == OP_BRA) || (opcode == OP_BFS && flag) || (opcode == OP_BFC && !flag);
  assign uses_operand = (opcode >= OP_LDI) && (opcode <= OP_BRA);

  // Every instruction boundary funnels through here so a pending interrupt is never missed.
  assign fetch_or_int = (IRQ && int_en) ? S_INT : S_FETCH0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_FETCH0;
      int_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      int_en <= int_en_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    int_en_nxt = int_en;
    IR_Load    = 1'b0;
    MAR_Load   = 1'b0;
    PC_Load    = 1'b0;
    PC_Inc     = 1'b0;
    CCR_Load   = 1'b0;
    EPC_Load   = 1'b0;
    Reg_Load   = '0;
    Rd_Sel     = '0;
    Rs_Sel     = '0;
    ALU_Sel    = 3'd0;
    Bus1_Sel   = 2'd0;
    Bus2_Sel   = 2'd0;
    mem_req    = 1'b0;
    write      = 1'b0;
    IACK       = 1'b0;
    Halted     = 1'b0;

    // Gating on Reset keeps every output quiet, including mid-access, without waiting for a clock.
    if (!Reset) begin
      Rd_Sel = rd;
      Rs_Sel = rs;
      case (state)
        S_FETCH0: begin
          MAR_Load  = 1'b1;
          Bus2_Sel  = 2'd1;
          state_nxt = S_FETCH1;
        end
        S_FETCH1: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            PC_Inc    = 1'b1;
            state_nxt = S_FETCH2;
          end
        end
        S_FETCH2: begin
          Bus2_Sel  = 2'd2;
          IR_Load   = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: state_nxt = uses_operand ? S_OP0 : S_EX;
        S_OP0: begin
          MAR_Load  = 1'b1;
          Bus2_Sel  = 2'd1;
          state_nxt = S_OP1;
        end
        S_OP1: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            PC_Inc    = 1'b1;
            state_nxt = S_OP2;
          end
        end
        S_OP2: begin
          Bus2_Sel = 2'd2;
          if (opcode == OP_LDI) begin
            Reg_Load  = rd_onehot;
            state_nxt = fetch_or_int;
          end else if (opcode == OP_LDD || opcode == OP_STD) begin
            MAR_Load  = 1'b1;
            state_nxt = S_OP3;
          end else begin
            PC_Load   = taken;
            state_nxt = fetch_or_int;
          end
        end
        S_OP3: begin
          mem_req = 1'b1;
          if (opcode == OP_STD) begin
            write    = 1'b1;
            Bus1_Sel = 2'd1;
          end else begin
            Bus2_Sel = 2'd2;
          end
          if (mem_ready) begin
            if (opcode == OP_LDD) Reg_Load = rd_onehot;
            state_nxt = fetch_or_int;
          end
        end
        S_EX: begin
          state_nxt = fetch_or_int;
          if (opcode[3]) begin
            Bus1_Sel = 2'd1;
            ALU_Sel  = opcode[2:0];
            CCR_Load = 1'b1;
            if (opcode[2:0] != 3'd7) Reg_Load = rd_onehot;
          end else if (opcode == OP_MISC) begin
            if (rs == RSEL_W'(0)) begin
              state_nxt = S_HALT;
            end else if (rs == RSEL_W'(1)) begin
              Bus1_Sel   = 2'd3;
              Bus2_Sel   = 2'd1;
              PC_Load    = 1'b1;
              int_en_nxt = 1'b1;
            end else if (rs == RSEL_W'(2)) begin
              int_en_nxt = 1'b1;
            end else if (rs == RSEL_W'(3)) begin
              int_en_nxt = 1'b0;
            end
          end
        end
        S_HALT: begin
          Halted = 1'b1;
          if (IRQ && int_en) state_nxt = S_INT;
        end
        S_INT: begin
          EPC_Load   = 1'b1;
          Bus2_Sel   = 2'd3;
          PC_Load    = 1'b1;
          IACK       = 1'b1;
          int_en_nxt = 1'b0;
          state_nxt  = S_FETCH0;
        end
        default: state_nxt = S_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_param.sv
// Directed bench for control_unit_param: a 4-register and a 16-register instance, observed one at a time.
module tb_control_unit_param;

  logic        Clk = 1'b0;
  logic        rst4, rst16, sel;
  logic [11:0] ir_drv;
  logic [3:0]  ccr;
  logic        mem_ready, irq;

  always #5 Clk = ~Clk;

  logic        a_irld, a_mar, a_pcl, a_pci, a_ccr, a_epc, a_mreq, a_wr, a_iack, a_halt;
  logic [3:0]  a_rl;
  logic [1:0]  a_rd, a_rs, a_b1, a_b2;
  logic [2:0]  a_alu;
  logic        b_irld, b_mar, b_pcl, b_pci, b_ccr, b_epc, b_mreq, b_wr, b_iack, b_halt;
  logic [15:0] b_rl;
  logic [3:0]  b_rd, b_rs;
  logic [1:0]  b_b1, b_b2;
  logic [2:0]  b_alu;

  control_unit_param #(.NUM_REGS(4)) dut4 (
    .Clk(Clk), .Reset(rst4), .IR(ir_drv[7:0]), .CCR_Result(ccr), .mem_ready(mem_ready), .IRQ(irq),
    .IR_Load(a_irld), .MAR_Load(a_mar), .PC_Load(a_pcl), .PC_Inc(a_pci), .CCR_Load(a_ccr),
    .EPC_Load(a_epc), .Reg_Load(a_rl), .Rd_Sel(a_rd), .Rs_Sel(a_rs), .ALU_Sel(a_alu),
    .Bus1_Sel(a_b1), .Bus2_Sel(a_b2), .mem_req(a_mreq), .write(a_wr), .IACK(a_iack), .Halted(a_halt));

  control_unit_param #(.NUM_REGS(16)) dut16 (
    .Clk(Clk), .Reset(rst16), .IR(ir_drv), .CCR_Result(ccr), .mem_ready(mem_ready), .IRQ(irq),
    .IR_Load(b_irld), .MAR_Load(b_mar), .PC_Load(b_pcl), .PC_Inc(b_pci), .CCR_Load(b_ccr),
    .EPC_Load(b_epc), .Reg_Load(b_rl), .Rd_Sel(b_rd), .Rs_Sel(b_rs), .ALU_Sel(b_alu),
    .Bus1_Sel(b_b1), .Bus2_Sel(b_b2), .mem_req(b_mreq), .write(b_wr), .IACK(b_iack), .Halted(b_halt));

  logic [24:0] all4;
  logic [40:0] all16;
  assign all4  = {a_irld, a_mar, a_pcl, a_pci, a_ccr, a_epc, a_rl, a_rd, a_rs, a_alu, a_b1, a_b2,
                  a_mreq, a_wr, a_iack, a_halt};
  assign all16 = {b_irld, b_mar, b_pcl, b_pci, b_ccr, b_epc, b_rl, b_rd, b_rs, b_alu, b_b1, b_b2,
                  b_mreq, b_wr, b_iack, b_halt};

  // Observed instance
  logic        o_irld, o_mar, o_pcl, o_pci, o_ccr, o_epc, o_mreq, o_wr, o_iack, o_halt;
  logic [15:0] o_rl;
  logic [2:0]  o_alu;
  logic [1:0]  o_b1, o_b2;
  always_comb begin
    o_irld = sel ? b_irld : a_irld;  o_mar  = sel ? b_mar  : a_mar;
    o_pcl  = sel ? b_pcl  : a_pcl;   o_pci  = sel ? b_pci  : a_pci;
    o_ccr  = sel ? b_ccr  : a_ccr;   o_epc  = sel ? b_epc  : a_epc;
    o_mreq = sel ? b_mreq : a_mreq;  o_wr   = sel ? b_wr   : a_wr;
    o_iack = sel ? b_iack : a_iack;  o_halt = sel ? b_halt : a_halt;
    o_rl   = sel ? b_rl   : {12'd0, a_rl};
    o_alu  = sel ? b_alu  : a_alu;
    o_b1   = sel ? b_b1   : a_b1;    o_b2   = sel ? b_b2   : a_b2;
  end

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endtask

  // Per-run activity statistics
  int          c_pci, c_pcl, c_mreq, c_wr, c_ccr, c_irld, c_iack, c_epc, c_halt, c_any, c_bad;
  int          rl_cyc, iack_cyc;
  logic [15:0] rl_or;
  logic [2:0]  alu_ex;
  logic [3:0]  iack_bus, pcl_bus;
  logic        start_ok;

  task automatic run(input logic [11:0] ir, input logic [3:0] c, input int n,
                     input logic [31:0] rdy, input logic [31:0] irqm);
    c_pci = 0; c_pcl = 0; c_mreq = 0; c_wr = 0; c_ccr = 0; c_irld = 0; c_iack = 0; c_epc = 0;
    c_halt = 0; c_any = 0; c_bad = 0; rl_cyc = 0; iack_cyc = 0; rl_or = '0; alu_ex = '0;
    iack_bus = '0; pcl_bus = '0; start_ok = 1'b0;
    ir_drv = ir; ccr = c;
    for (int i = 1; i <= n; i++) begin
      mem_ready = rdy[i-1];
      irq = irqm[i-1];
      @(negedge Clk);
      if (i == 1) start_ok = o_mar && o_b1 == 2'd0 && o_b2 == 2'd1 && !o_mreq && !o_halt;
      c_pci += int'(o_pci); c_pcl += int'(o_pcl); c_mreq += int'(o_mreq); c_wr += int'(o_wr);
      c_ccr += int'(o_ccr); c_irld += int'(o_irld); c_epc += int'(o_epc); c_halt += int'(o_halt);
      if (o_irld || o_mar || o_pcl || o_pci || o_ccr || o_epc || o_mreq || o_rl != 0) c_any++;
      if (!$onehot0(o_rl) || (o_wr && !o_mreq)) c_bad++;
      if (o_rl != 0) begin rl_or |= o_rl; rl_cyc = i; end
      if (o_ccr) alu_ex = o_alu;
      if (o_iack) begin c_iack++; iack_cyc = i; iack_bus = {o_b1, o_b2}; end
      if (o_pcl) pcl_bus = {o_b1, o_b2};
      @(posedge Clk); #1;
    end
  endtask

  typedef struct {
    logic [11:0] ir;
    logic [3:0]  ccr;
    int          cyc, pci, pcl, mreq, wr, ccrl;
    logic [15:0] rl;
    int          rlc;
    logic [2:0]  alu;
  } vec_t;

  vec_t tbl[15];
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    //         ir      ccr  cyc pci pcl mreq wr ccrl  rl       rlc alu
    tbl[0]  = '{12'h00, 4'h0, 5, 1, 0, 1, 0, 0, 16'h0000, 0, 3'd0};  // NOP
    tbl[1]  = '{12'h18, 4'h0, 7, 2, 0, 2, 0, 0, 16'h0004, 7, 3'd0};  // LDI r2
    tbl[2]  = '{12'h24, 4'h0, 8, 2, 0, 3, 0, 0, 16'h0002, 8, 3'd0};  // LDD r1
    tbl[3]  = '{12'h33, 4'h0, 8, 2, 0, 3, 1, 0, 16'h0000, 0, 3'd0};  // STD r3
    tbl[4]  = '{12'h41, 4'h2, 7, 2, 1, 2, 0, 0, 16'h0000, 0, 3'd0};  // BFS Z set
    tbl[5]  = '{12'h41, 4'h0, 7, 2, 0, 2, 0, 0, 16'h0000, 0, 3'd0};  // BFS Z clear
    tbl[6]  = '{12'h51, 4'h2, 7, 2, 0, 2, 0, 0, 16'h0000, 0, 3'd0};  // BFC Z set
    tbl[7]  = '{12'h51, 4'h0, 7, 2, 1, 2, 0, 0, 16'h0000, 0, 3'd0};  // BFC Z clear
    tbl[8]  = '{12'h60, 4'h0, 7, 2, 1, 2, 0, 0, 16'h0000, 0, 3'd0};  // BRA
    tbl[9]  = '{12'h43, 4'h8, 7, 2, 1, 2, 0, 0, 16'h0000, 0, 3'd0};  // BFS V set
    tbl[10] = '{12'h8D, 4'h0, 5, 1, 0, 1, 0, 1, 16'h0008, 5, 3'd0};  // ALU0 r3,r1
    tbl[11] = '{12'hA3, 4'h0, 5, 1, 0, 1, 0, 1, 16'h0001, 5, 3'd2};  // ALU2 r0,r3
    tbl[12] = '{12'hF8, 4'h0, 5, 1, 0, 1, 0, 1, 16'h0000, 0, 3'd7};  // compare
    tbl[13] = '{12'h72, 4'h0, 5, 1, 0, 1, 0, 0, 16'h0000, 0, 3'd0};  // EI
    tbl[14] = '{12'h73, 4'h0, 5, 1, 0, 1, 0, 0, 16'h0000, 0, 3'd0};  // DI

    rst4 = 1'b1; rst16 = 1'b1; sel = 1'b0; ir_drv = 12'hFFF; ccr = 4'hF; mem_ready = 1'b1; irq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk($sformatf("reset_outs4_c%0d", i), all4, 0);
      chk($sformatf("reset_outs16_c%0d", i), longint'(all16 != 0), 0);
    end
    @(posedge Clk); #1;
    rst4 = 1'b0; irq = 1'b0; ir_drv = 12'h000; ccr = 4'h0;
    @(negedge Clk);
    chk("first_mar_load", o_mar, 1);
    chk("first_bus1", o_b1, 0);
    chk("first_bus2", o_b2, 1);
    @(posedge Clk); #1;
    mem_ready = 1'b0;
    @(negedge Clk);
    chk("fetch1_mem_req", o_mreq, 1);
    #2 rst4 = 1'b1;
    #1 chk("async_reset_mem_req", o_mreq, 0);
    chk("async_reset_outs", all4, 0);
    @(posedge Clk); #1;
    rst4 = 1'b0; mem_ready = 1'b1;

    foreach (tbl[k]) begin
      run(tbl[k].ir, tbl[k].ccr, tbl[k].cyc, ONES, 32'h0);
      chk($sformatf("v%0d_start", k), start_ok, 1);
      chk($sformatf("v%0d_pc_inc", k), c_pci, tbl[k].pci);
      chk($sformatf("v%0d_pc_load", k), c_pcl, tbl[k].pcl);
      chk($sformatf("v%0d_mem_req", k), c_mreq, tbl[k].mreq);
      chk($sformatf("v%0d_write", k), c_wr, tbl[k].wr);
      chk($sformatf("v%0d_ccr_load", k), c_ccr, tbl[k].ccrl);
      chk($sformatf("v%0d_reg_load", k), rl_or, tbl[k].rl);
      chk($sformatf("v%0d_reg_load_cyc", k), rl_cyc, tbl[k].rlc);
      chk($sformatf("v%0d_alu_sel", k), alu_ex, tbl[k].alu);
      chk($sformatf("v%0d_ir_load", k), c_irld, 1);
      chk($sformatf("v%0d_protocol", k), c_bad, 0);
    end

    // STD with three wait states in the store access
    run(12'h33, 4'h0, 11, 32'hFFFF_FC7F, 32'h0);
    chk("stdw_start", start_ok, 1);
    chk("stdw_write", c_wr, 4);
    chk("stdw_mem_req", c_mreq, 6);
    chk("stdw_pc_inc", c_pci, 2);
    chk("stdw_protocol", c_bad, 0);
    // NOP with one wait state in instruction fetch
    run(12'h00, 4'h0, 6, 32'hFFFF_FFFD, 32'h0);
    chk("nopw_start", start_ok, 1);
    chk("nopw_pc_inc", c_pci, 1);
    chk("nopw_mem_req", c_mreq, 2);

    // Interrupt raised during an LDD wait state
    run(12'h72, 4'h0, 5, ONES, 32'h0);
    chk("ei_start", start_ok, 1);
    run(12'h24, 4'h0, 9, 32'hFFFF_FF7F, 32'hFFFF_FF80);
    chk("lddirq_start", start_ok, 1);
    chk("lddirq_no_iack", c_iack, 0);
    chk("lddirq_reg_load", rl_or, 16'h0002);
    chk("lddirq_reg_cyc", rl_cyc, 9);
    run(12'h00, 4'h0, 1, ONES, ONES);
    chk("int_iack", c_iack, 1);
    chk("int_epc_load", c_epc, 1);
    chk("int_pc_load", c_pcl, 1);
    chk("int_buses", iack_bus, 4'b0011);
    run(12'h00, 4'h0, 5, ONES, ONES);
    chk("masked_start", start_ok, 1);
    chk("masked_no_iack", c_iack, 0);
    run(12'h71, 4'h0, 5, ONES, ONES);
    chk("rti_start", start_ok, 1);
    chk("rti_pc_load", c_pcl, 1);
    chk("rti_buses", pcl_bus, 4'b1101);
    chk("rti_no_iack", c_iack, 0);
    run(12'h00, 4'h0, 6, ONES, ONES);
    chk("reint_start", start_ok, 1);
    chk("reint_iack", c_iack, 1);
    chk("reint_iack_cyc", iack_cyc, 6);
    run(12'h00, 4'h0, 5, ONES, 32'h0);
    chk("after_int_start", start_ok, 1);

    // 16-register instance
    sel = 1'b1; rst16 = 1'b0;
    run(12'hF90, 4'h0, 5, ONES, 32'h0);
    chk("r16_cmp_start", start_ok, 1);
    chk("r16_cmp_ccr_load", c_ccr, 1);
    chk("r16_cmp_reg_load", rl_or, 0);
    chk("r16_cmp_alu", alu_ex, 7);
    run(12'h992, 4'h0, 5, ONES, 32'h0);
    chk("r16_alu1_start", start_ok, 1);
    chk("r16_alu1_reg_load", rl_or, 16'h0200);
    chk("r16_alu1_alu", alu_ex, 1);
    chk("r16_alu1_protocol", c_bad, 0);
    run(12'h702, 4'h0, 5, ONES, 32'h0);
    chk("r16_ei_start", start_ok, 1);
    run(12'h700, 4'h0, 5, ONES, 32'h0);
    chk("halt_start", start_ok, 1);
    chk("halt_not_yet", c_halt, 0);
    run(12'h700, 4'h0, 3, ONES, 32'h0);
    chk("halt_held", c_halt, 3);
    chk("halt_no_strobes", c_any, 0);
    run(12'h700, 4'h0, 1, ONES, ONES);
    chk("halt_irq_cycle", c_halt, 1);
    run(12'h700, 4'h0, 1, ONES, ONES);
    chk("halt_exit_halted", c_halt, 0);
    chk("halt_exit_iack", c_iack, 1);
    chk("halt_exit_epc", c_epc, 1);
    run(12'h000, 4'h0, 5, ONES, 32'h0);
    chk("halt_exit_fetch", start_ok, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/control_unit_param.md
Name: control_unit_param

Overview:
- Parametrised next-generation control unit for the multi-register CPU.
- Fetch/decode/execute FSM driving a NUM_REGS register file, ALU, PC, MAR, EPC and bus muxes.
- Adds a wait-state memory handshake (mem_req/mem_ready), vectored interrupts (IRQ/IACK, EPC, RTI, EI/DI) and HALT.
- Sits between the instruction register/CCR and the datapath; all datapath registers are external.

Parameters:
- NUM_REGS, 4, number of general registers; power of two, 4..16.
- RSEL_W, clog2(NUM_REGS), register-select width (derived localparam).
- IR_W, 4+2*RSEL_W, IR width (derived localparam).

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- IR  in  IR_W  {opcode[3:0], rd[RSEL_W-1:0], rs[RSEL_W-1:0]}.
- CCR_Result  in  4  flags: [0]C [1]Z [2]N [3]V.
- mem_ready  in  1  memory completes the current access this cycle.
- IRQ  in  1  level interrupt request.
- IR_Load, MAR_Load, PC_Load, PC_Inc, CCR_Load, EPC_Load  out  1  datapath load strobes.
- Reg_Load  out  NUM_REGS  one-hot register write enable.
- Rd_Sel, Rs_Sel  out  RSEL_W  rd/rs fields of IR; ALU A = reg[Rd_Sel].
- ALU_Sel  out  3  ALU function.
- Bus1_Sel  out  2  0=PC, 1=reg[Rs_Sel], 2=reg[Rd_Sel], 3=EPC.
- Bus2_Sel  out  2  0=ALU, 1=Bus1, 2=from_memory, 3=interrupt vector.
- mem_req  out  1  memory access active.
- write  out  1  store qualifier, valid with mem_req.
- IACK  out  1  interrupt acknowledge pulse.
- Halted  out  1  core in HALT.

Behaviour:
- Moore FSM. Outputs decode from the state only, except Reg_Load/PC_Load/PC_Inc where noted. While Reset is high, state = FETCH0, int_en = 0, and every output is 0.
- Opcodes:
  - 0 NOP.
  - 1 LDI rd.
  - 2 LDD rd (direct address).
  - 3 STD rs.
  - 4 BFS: branch if CCR_Result[rs[1:0]] = 1.
  - 5 BFC: branch if that flag = 0.
  - 6 BRA.
  - 7 MISC, by rs: 0 HALT, 1 RTI, 2 EI, 3 DI, other = NOP.
  - 8-F ALU: ALU_Sel = opcode[2:0], rd <= rd op rs, CCR_Load. For ALU_Sel = 7 (compare), CCR_Load only, no Reg_Load.
- Fetch: FETCH0 (Bus1=PC, Bus2=1, MAR_Load) -> FETCH1 (mem_req; hold until mem_ready; PC_Inc only in the mem_ready cycle) -> FETCH2 (Bus2=2, IR_Load) -> DECODE (no strobes).
- Operand read, shared by LDI/LDD/STD/branches: OP0 MAR<=PC, then OP1 mem_req with PC_Inc on mem_ready.
  - LDI: OP2 Bus2=2, Reg_Load[rd].
  - LDD/STD: OP2 Bus2=2, MAR_Load; then OP3 mem_req until mem_ready.
    - LDD OP3: Reg_Load[rd] in the mem_ready cycle, with Bus2=2.
    - STD OP3: write=1, Bus1=1 (rs).
  - Branch: OP2 Bus2=2 with PC_Load=1 iff taken (BRA always taken). Not taken = no strobe; PC already advanced.
- ALU: EX (Bus1=1, Bus2=0) -> FETCH0.
- RTI: EX Bus1=3, Bus2=1, PC_Load, int_en <= 1.
- EI/DI: set/clear int_en in EX.
- HALT: enter HALT, Halted=1, no strobes. Exit only via interrupt (IRQ & int_en) or Reset.
- Latency with mem_ready tied 1: NOP/MISC 5, ALU 5, LDI 7, branch 7, LDD 8, STD 8 cycles. Each wait state adds 1 cycle.
- Interrupt check:
  - Evaluated on every transition into FETCH0 and in HALT.
  - If IRQ & int_en, the next state is INT instead.
  - INT, one cycle: EPC_Load (Bus1=0), Bus2=3, PC_Load, IACK=1, int_en <= 0; then -> FETCH0.
  - IRQ is never taken mid-instruction or during a mem_req wait.
- mem_req stays high continuously until mem_ready. mem_ready without mem_req is ignored. write is never high without mem_req.
- Reset asserted mid-access drops mem_req/write immediately (asynchronous).
- Reg_Load is always one-hot or zero.

Test Plan:
- Reset high 2 cycles, release: all outputs 0 during reset; first cycle after release MAR_Load=1, Bus1_Sel=0, Bus2_Sel=1.
- NUM_REGS=4, IR=0x1_2_0 (LDI r2), mem_ready=1 -> Reg_Load=4'b0100 exactly in cycle 7; PC_Inc pulses exactly twice.
- STD r3 with mem_ready low for 3 cycles in OP3 -> mem_req and write held 4 cycles, PC_Inc unaffected, then FETCH0.
- CCR_Result=4'b0010, BFS rs=1 -> PC_Load in OP2. CCR_Result=0 -> no PC_Load. BFC with same two values -> inverse.
- EI, then IRQ=1 raised during an LDD wait state -> INT entered only after LDD completes; IACK/EPC_Load/PC_Load for 1 cycle; second IRQ ignored until RTI.
- NUM_REGS=16, ALU opcode 0xF, rd=9 -> CCR_Load=1, Reg_Load=0. Opcode 0x9, rd=9 -> Reg_Load bit 9 only. HALT then IRQ with int_en=1 -> Halted falls, INT.
